// File: rtl/adc_push_pacer.sv
// ADC sample pacer: buffers converter samples in a FIFO and pushes them to the
// correlator bank no faster than one every max(Interval,1) cycles.
module adc_push_pacer #(
    parameter int unsigned DEPTH = 16,
    parameter logic [31:0] BASE  = 32'hFE000200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] Wdata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] Rdata,
    input  logic [15:0] SampleIn,
    input  logic        SampleValid,
    output logic        SampleReady,
    output logic [15:0] ADC,
    output logic        PushADC
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [31:0] ADDR_CTRL   = BASE;
    localparam logic [31:0] ADDR_INTV   = BASE + 32'd4;
    localparam logic [31:0] ADDR_STATUS = BASE + 32'd8;
    localparam logic [31:0] ADDR_DROP   = BASE + 32'd12;

    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           enable;
    logic [15:0]    interval;
    logic           overflow;
    logic [31:0]    drop_count;
    logic [15:0]    spacing;

    logic           full;
    logic           empty;
    logic           wr_ctrl;
    logic           wr_intv;
    logic           wr_status;
    logic           wr_drop;
    logic           flush;
    logic           accept;
    logic           drop;
    logic           pop;
    logic [15:0]    spacing_load;
    logic [31:0]    status;

    // Datapath decisions for this cycle; a flush suppresses accept, drop and pop.
    always_comb begin
        full         = (level == LW'(DEPTH));
        empty        = (level == '0);
        wr_ctrl      = write && (addr == ADDR_CTRL);
        wr_intv      = write && (addr == ADDR_INTV);
        wr_status    = write && (addr == ADDR_STATUS);
        wr_drop      = write && (addr == ADDR_DROP);
        flush        = wr_ctrl && Wdata[1];
        accept       = SampleValid && !full && !flush;
        drop         = SampleValid && full && !flush;
        pop          = enable && !empty && (spacing == 16'd0) && !flush;
        spacing_load = (interval == 16'd0) ? 16'd0 : (interval - 16'd1);
        status       = {21'd0, overflow, full, empty, 1'b0, 7'(level)};
    end

    assign SampleReady = !full;

    // Combinational register read mux; unmapped or idle reads return 0.
    always_comb begin
        Rdata = 32'd0;
        if (read) begin
            case (addr)
                ADDR_CTRL:   Rdata = {31'd0, enable};
                ADDR_INTV:   Rdata = {16'd0, interval};
                ADDR_STATUS: Rdata = status;
                ADDR_DROP:   Rdata = drop_count;
                default:     Rdata = 32'd0;
            endcase
        end
    end

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= SampleIn;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Pop-to-pop spacing counter; keeps counting down even while disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            spacing <= 16'd0;
        end else if (flush) begin
            spacing <= 16'd0;
        end else if (pop) begin
            spacing <= spacing_load;
        end else if (spacing != 16'd0) begin
            spacing <= spacing - 16'd1;
        end
    end

    // Output stage: head sample and one-cycle strobe the cycle after a pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ADC     <= 16'd0;
            PushADC <= 1'b0;
        end else begin
            PushADC <= pop;
            if (pop) begin
                ADC <= mem[rd_ptr];
            end
        end
    end

    // Control and interval registers; flush bit is a strobe and is never stored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enable   <= 1'b0;
            interval <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                enable <= Wdata[0];
            end
            if (wr_intv) begin
                interval <= Wdata[15:0];
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats the W1C.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (wr_status && Wdata[10]) begin
            overflow <= 1'b0;
        end
    end

    // Saturating drop counter; a bus write beats a concurrent drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_count <= 32'd0;
        end else if (wr_drop) begin
            drop_count <= Wdata;
        end else if (drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_adc_push_pacer.sv
// Randomized bench for adc_push_pacer against a queue-based reference model.
module tb_adc_push_pacer;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hFE000200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] Wdata;
    logic        write;
    logic        read;
    logic [31:0] Rdata;
    logic [15:0] SampleIn;
    logic        SampleValid;
    logic        SampleReady;
    logic [15:0] ADC;
    logic        PushADC;

    adc_push_pacer #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
        .read(read), .Rdata(Rdata), .SampleIn(SampleIn),
        .SampleValid(SampleValid), .SampleReady(SampleReady), .ADC(ADC),
        .PushADC(PushADC)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, spacing as the earliest cycle a pop may occur.
    logic [15:0] q[$];
    bit          m_en;
    logic [15:0] m_int;
    bit          m_ovf;
    logic [31:0] m_drop;
    longint      cyc;
    longint      m_next;
    bit          m_push;
    logic [15:0] m_adc;

    int n_chk  = 0;
    int n_pass = 0;
    int np;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int lv;
        logic [31:0] st;
        lv = q.size();
        st = 32'(lv);
        if (lv == 0) st = st | 32'h100;
        if (lv == int'(DEPTH)) st = st | 32'h200;
        if (m_ovf) st = st | 32'h400;
        if (a == BASE) return {31'd0, m_en};
        if (a == BASE + 32'd4) return {16'd0, m_int};
        if (a == BASE + 32'd8) return st;
        if (a == BASE + 32'd12) return m_drop;
        return 32'd0;
    endfunction

    // Apply one clock edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        bit flush, full, pop, acc, drp;
        longint s;
        s = (m_int == 16'd0) ? 1 : longint'(m_int);
        if (!rst) begin
            q.delete();
            m_en = 0; m_int = 16'd0; m_ovf = 0; m_drop = 32'd0;
            m_next = cyc + 1; m_push = 0; m_adc = 16'd0;
        end else begin
            flush = write && (addr == BASE) && Wdata[1];
            full  = (q.size() == int'(DEPTH));
            pop   = m_en && (q.size() != 0) && (cyc >= m_next) && !flush;
            acc   = SampleValid && !full && !flush;
            drp   = SampleValid && full && !flush;
            m_push = pop;
            if (pop) begin
                m_adc  = q.pop_front();
                m_next = cyc + s;
            end
            if (acc) q.push_back(SampleIn);
            if (flush) begin
                q.delete();
                m_next = cyc + 1;
            end
            if (drp) m_ovf = 1;
            else if (write && (addr == BASE + 32'd8) && Wdata[10]) m_ovf = 0;
            if (write && (addr == BASE + 32'd12)) m_drop = Wdata;
            else if (drp && (m_drop != 32'hFFFF_FFFF)) m_drop = m_drop + 32'd1;
            if (write && (addr == BASE)) m_en = Wdata[0];
            if (write && (addr == BASE + 32'd4)) m_int = Wdata[15:0];
        end
        cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("push", 32'(PushADC), 32'(m_push));
        chk("adc", 32'(ADC), 32'(m_adc));
        chk("ready", 32'(SampleReady), 32'(q.size() != int'(DEPTH)));
        if (PushADC) np++;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; Wdata = d; write = 1'b1;
        tick();
        write = 1'b0; addr = 32'd0; Wdata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        addr = a; read = 1'b1;
        #1;
        chk(tag, Rdata, model_rd(a));
        read = 1'b0; addr = 32'd0;
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a; read = 1'b1;
        #1;
        chk(tag, Rdata, exp);
        read = 1'b0; addr = 32'd0;
    endtask

    task automatic push_samples(input int n, input logic [15:0] first, input bit rnd);
        for (int i = 0; i < n; i++) begin
            SampleValid = 1'b1;
            SampleIn    = rnd ? 16'($urandom) : first + 16'(i);
            tick();
        end
        SampleValid = 1'b0;
    endtask

    initial begin
        int dens;
        int k;
        logic [31:0] d;
        rst = 1'b0; addr = 32'd0; Wdata = 32'd0; write = 1'b0; read = 1'b0;
        SampleIn = 16'd0; SampleValid = 1'b0;
        cyc = 0; m_next = 0; np = 0;
        m_en = 0; m_int = 16'd0; m_ovf = 0; m_drop = 32'd0; m_push = 0; m_adc = 16'd0;

        // Reset state
        tick(); tick();
        rd_exp(BASE, 32'd0, "rst_ctrl");
        rd_exp(BASE + 32'd8, 32'h100, "rst_status");
        rd_exp(BASE + 32'd12, 32'd0, "rst_drop");
        addr = BASE + 32'd8; #1;
        chk("rdata_idle", Rdata, 32'd0);
        addr = 32'd0;
        rst = 1'b1;
        tick();

        // Back-to-back stream at Interval 0
        wr(BASE + 32'd4, 32'd0);
        wr(BASE, 32'd1);
        np = 0;
        push_samples(5, 16'h0001, 0);
        repeat (6) tick();
        chk("b2b_npush", 32'(np), 32'd5);
        chk("b2b_last", 32'(ADC), 32'h0005);

        // Interval 4 with three preloaded samples
        wr(BASE, 32'd0);
        wr(BASE + 32'd4, 32'd4);
        push_samples(3, 16'h0010, 0);
        np = 0;
        wr(BASE, 32'd1);
        repeat (16) tick();
        chk("intv4_npush", 32'(np), 32'd3);
        rd_exp(BASE + 32'd8, 32'h100, "intv4_status");

        // Overflow, drop count, W1C and saturation
        wr(BASE, 32'd0);
        push_samples(int'(DEPTH) + 3, 16'd0, 1);
        chk("full_ready", 32'(SampleReady), 32'd0);
        rd_exp(BASE + 32'd8, 32'(DEPTH) | 32'h600, "ovf_status");
        rd_exp(BASE + 32'd12, 32'd3, "ovf_drop");
        wr(BASE + 32'd8, 32'h400);
        rd_exp(BASE + 32'd8, 32'(DEPTH) | 32'h200, "w1c_status");
        wr(BASE + 32'd12, 32'hFFFF_FFFE);
        push_samples(3, 16'd0, 1);
        rd_exp(BASE + 32'd12, 32'hFFFF_FFFF, "drop_sat");

        // Flush with a concurrent incoming sample; overflow stays set
        wr(BASE, 32'd2);
        push_samples(10, 16'h0100, 0);
        np = 0;
        SampleValid = 1'b1; SampleIn = 16'hBEEF;
        wr(BASE, 32'd3);
        SampleValid = 1'b0;
        rd_exp(BASE + 32'd8, 32'h500, "flush_status");
        rd_exp(BASE, 32'd1, "flush_ctrl");
        repeat (5) tick();
        chk("flush_npush", 32'(np), 32'd0);

        // Randomized traffic and register accesses
        dens = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = int'($urandom_range(1, 8));
            SampleValid = (int'($urandom % 8) < dens);
            SampleIn    = 16'($urandom);
            if ($urandom % 10 == 0) begin
                k = int'($urandom % 4);
                case (k)
                    0:       d = {30'd0, ($urandom % 12 == 0), ($urandom % 4 != 0)};
                    1:       d = $urandom % 6;
                    2:       d = $urandom;
                    default: d = ($urandom % 2 == 0) ? $urandom : 32'hFFFF_FFFD;
                endcase
                addr = BASE + 32'(4 * k); Wdata = d; write = 1'b1;
            end
            tick();
            write = 1'b0; addr = 32'd0; Wdata = 32'd0;
            if ($urandom % 8 == 0) rd(BASE + 32'(4 * ($urandom % 5)), "rand_rd");
        end
        SampleValid = 1'b0;

        // Mid-stream reset at Interval 2
        wr(BASE, 32'd2);
        wr(BASE + 32'd4, 32'd2);
        wr(BASE, 32'd1);
        push_samples(int'(DEPTH), 16'h0200, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        np = 0;
        repeat (8) tick();
        chk("rst_npush", 32'(np), 32'd0);
        chk("rst_adc", 32'(ADC), 32'd0);
        rd_exp(BASE, 32'd0, "mrst_ctrl");
        rd_exp(BASE + 32'd4, 32'd0, "mrst_intv");
        rd_exp(BASE + 32'd8, 32'h100, "mrst_status");
        rd_exp(BASE + 32'd12, 32'd0, "mrst_drop");

        // Pointer wrap with continuous accept and pop at Interval 1
        wr(BASE + 32'd4, 32'd1);
        wr(BASE, 32'd1);
        np = 0;
        push_samples(3 * int'(DEPTH), 16'h1000, 0);
        repeat (4) tick();
        chk("wrap_npush", 32'(np), 32'(3 * DEPTH));
        chk("wrap_last", 32'(ADC), 32'h1000 + 32'(3 * DEPTH - 1));
        rd_exp(BASE + 32'd12, 32'd0, "wrap_drop");
        rd_exp(BASE + 32'd8, 32'h100, "wrap_status");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
